// File: rtl/mem_server.sv
// Fixed-latency word-addressed memory serving the val/rdy request/response protocol.
// Responses leave in acceptance order. A credit counter bounds how many requests are outstanding.
module mem_server #(
  parameter int p_opaq_bits  = 8,
  parameter int p_num_words  = 256,
  parameter int p_latency    = 2,
  parameter int p_resp_depth = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   req_val,
  output logic                   req_rdy,
  input  logic                   req_op,
  input  logic [p_opaq_bits-1:0] req_opaque,
  input  logic [31:0]            req_addr,
  input  logic [31:0]            req_data,
  output logic                   resp_val,
  input  logic                   resp_rdy,
  output logic                   resp_op,
  output logic [p_opaq_bits-1:0] resp_opaque,
  output logic [31:0]            resp_data,
  input  logic                   init_en,
  input  logic [31:0]            init_addr,
  input  logic [31:0]            init_data
);
  localparam int AW = $clog2(p_num_words);
  localparam int NS = (p_latency > 1) ? p_latency - 1 : 1;
  localparam int PW = (p_resp_depth > 1) ? $clog2(p_resp_depth) : 1;
  localparam int CW = $clog2(p_resp_depth + 1);

  typedef struct packed {
    logic                   op;
    logic [p_opaq_bits-1:0] opaque;
    logic [31:0]            data;
  } resp_t;

  logic [31:0]    mem [p_num_words];
  resp_t          stage [NS];
  logic [NS-1:0]  stage_val;
  resp_t          fifo [p_resp_depth];
  logic [PW-1:0]  wr_ptr, rd_ptr;
  logic [CW-1:0]  fifo_cnt, count;
  logic [AW-1:0]  req_idx, init_idx;
  logic           accept, deq, enq;
  resp_t          new_resp, enq_resp, head;
  logic           unused_addr_bits;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PW'(p_resp_depth - 1)) ? '0 : p + PW'(1);
  endfunction

  assign req_idx  = req_addr[AW+1:2];
  assign init_idx = init_addr[AW+1:2];
  assign unused_addr_bits = ^{req_addr[31:AW+2], req_addr[1:0],
                              init_addr[31:AW+2], init_addr[1:0]};

  // Credit check uses only registered count plus rst/init_en, never resp_rdy or req_val.
  assign req_rdy  = !rst && !init_en && (count < CW'(p_resp_depth));
  assign accept   = req_val && req_rdy;
  assign resp_val = (fifo_cnt != '0);
  assign deq      = resp_val && resp_rdy;

  // NOTE: storage arrays (memory, stage payloads, FIFO slots) carry no reset; only the
  // valid bits, pointers and counters are cleared, so reset leaves memory contents intact.
  always_ff @(posedge clk) begin
    if (init_en)
      mem[init_idx] <= init_data;
    else if (accept && req_op)
      mem[req_idx] <= req_data;
  end

  always_comb begin
    new_resp.op     = req_op;
    new_resp.opaque = req_opaque;
    new_resp.data   = req_op ? 32'h0 : mem[req_idx];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stage_val <= '0;
    end else begin
      stage_val[0] <= accept;
      for (int i = 1; i < NS; i++)
        stage_val[i] <= stage_val[i-1];
    end
  end

  always_ff @(posedge clk) begin
    stage[0] <= new_resp;
    for (int i = 1; i < NS; i++)
      stage[i] <= stage[i-1];
  end

  // With a single-cycle latency the accepted request goes straight into the FIFO.
  assign enq      = (p_latency == 1) ? accept   : stage_val[NS-1];
  assign enq_resp = (p_latency == 1) ? new_resp : stage[NS-1];

  always_ff @(posedge clk) begin
    if (enq)
      fifo[wr_ptr] <= enq_resp;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
      count    <= '0;
    end else begin
      if (enq) wr_ptr <= next_ptr(wr_ptr);
      if (deq) rd_ptr <= next_ptr(rd_ptr);
      case ({enq, deq})
        2'b10:   fifo_cnt <= fifo_cnt + CW'(1);
        2'b01:   fifo_cnt <= fifo_cnt - CW'(1);
        default: fifo_cnt <= fifo_cnt;
      endcase
      case ({accept, deq})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Outputs read as zero whenever no response is presented, including right after reset.
  assign head        = fifo[rd_ptr];
  assign resp_op     = resp_val ? head.op     : 1'b0;
  assign resp_opaque = resp_val ? head.opaque : '0;
  assign resp_data   = resp_val ? head.data   : 32'h0;

endmodule

// File: tb/tb_mem_server.sv
// Self-checking bench for mem_server: directed vector table, multi-cycle corner sequences,
// and randomized traffic checked against a queue-based reference model.
module tb_mem_server;
  localparam int P_OPQ   = 8;
  localparam int P_WORDS = 256;
  localparam int P_LAT   = 2;
  localparam int P_DEPTH = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             req_val, req_rdy, req_op;
  logic [P_OPQ-1:0] req_opaque;
  logic [31:0]      req_addr, req_data;
  logic             resp_val, resp_rdy, resp_op;
  logic [P_OPQ-1:0] resp_opaque;
  logic [31:0]      resp_data;
  logic             init_en;
  logic [31:0]      init_addr, init_data;

  mem_server #(
    .p_opaq_bits(P_OPQ), .p_num_words(P_WORDS),
    .p_latency(P_LAT), .p_resp_depth(P_DEPTH)
  ) dut (
    .clk(clk), .rst(rst),
    .req_val(req_val), .req_rdy(req_rdy), .req_op(req_op),
    .req_opaque(req_opaque), .req_addr(req_addr), .req_data(req_data),
    .resp_val(resp_val), .resp_rdy(resp_rdy), .resp_op(resp_op),
    .resp_opaque(resp_opaque), .resp_data(resp_data),
    .init_en(init_en), .init_addr(init_addr), .init_data(init_data)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, want 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    logic             op;
    logic [P_OPQ-1:0] opq;
    logic [31:0]      data;
    int               ready_edge;
  } exp_t;

  exp_t        mq[$];
  logic [31:0] mm [P_WORDS];
  int          edge_cnt = 0;
  int          n_deq = 0;
  bit          mon_en = 0;

  always @(posedge clk) edge_cnt++;

  // A response accepted at edge k may be presented after edge k+P_LAT-1, once every
  // older response has left; the credit limit is the number of unanswered requests.
  always @(negedge clk) begin
    if (mon_en) begin
      logic exp_rdy, exp_val;
      exp_t e;
      exp_rdy = !rst && !init_en && (mq.size() < P_DEPTH);
      exp_val = (mq.size() > 0) && (mq[0].ready_edge <= edge_cnt);
      check("mon_req_rdy", req_rdy, exp_rdy);
      check("mon_resp_val", resp_val, exp_val);
      if (resp_val && exp_val) begin
        check("mon_resp_op", resp_op, mq[0].op);
        check("mon_resp_opaque", resp_opaque, mq[0].opq);
        check("mon_resp_data", resp_data, mq[0].data);
      end
      if (rst) begin
        mq.delete();
      end else begin
        if (resp_val && resp_rdy && mq.size() > 0) begin
          void'(mq.pop_front());
          n_deq++;
        end
        if (req_val && req_rdy) begin
          e.op         = req_op;
          e.opq        = req_opaque;
          e.data       = req_op ? 32'h0 : mm[req_addr[9:2]];
          e.ready_edge = edge_cnt + P_LAT;
          mq.push_back(e);
          if (req_op) mm[req_addr[9:2]] = req_data;
        end
      end
      if (init_en) mm[init_addr[9:2]] = init_data;
    end
  end

  // ---------------- directed vector table ----------------
  typedef struct {
    logic        ie;
    logic [31:0] ia, id;
    logic        rv, ro;
    logic [7:0]  q;
    logic [31:0] a, d;
    logic        er, ev, eo;
    logic [7:0]  eq;
    logic [31:0] ed;
  } vec_t;

  function automatic vec_t mk(input logic ie, input logic [31:0] ia, input logic [31:0] id,
                              input logic rv, input logic ro, input logic [7:0] q,
                              input logic [31:0] a, input logic [31:0] d,
                              input logic er, input logic ev, input logic eo,
                              input logic [7:0] eq, input logic [31:0] ed);
    vec_t v;
    v.ie = ie; v.ia = ia; v.id = id; v.rv = rv; v.ro = ro; v.q = q; v.a = a; v.d = d;
    v.er = er; v.ev = ev; v.eo = eo; v.eq = eq; v.ed = ed;
    return v;
  endfunction

  task automatic drive_idle();
    req_val = 0; req_op = 0; req_opaque = '0; req_addr = '0; req_data = '0;
    init_en = 0; init_addr = '0; init_data = '0;
  endtask

  function automatic logic [31:0] pat(input int i);
    return 32'hA5A5_0000 ^ (32'(i) * 32'h0001_0203);
  endfunction

  vec_t tbl [14];

  initial begin
    int acc, drops, base, got;

    // init 0x40 <- DEADBEEF, read it back; write/read-after-write; unaligned + wrapped address
    tbl[0]  = mk(1, 32'h40, 32'hDEADBEEF, 0, 0, 8'h00, 32'h0,   32'h0,        0, 0, 0, 8'h00, 32'h0);
    tbl[1]  = mk(0, 32'h0,  32'h0,        1, 0, 8'h03, 32'h40,  32'h0,        1, 0, 0, 8'h00, 32'h0);
    tbl[2]  = mk(0, 32'h0,  32'h0,        0, 0, 8'h00, 32'h0,   32'h0,        1, 0, 0, 8'h00, 32'h0);
    tbl[3]  = mk(0, 32'h0,  32'h0,        0, 0, 8'h00, 32'h0,   32'h0,        1, 1, 0, 8'h03, 32'hDEADBEEF);
    tbl[4]  = mk(0, 32'h0,  32'h0,        0, 0, 8'h00, 32'h0,   32'h0,        1, 0, 0, 8'h00, 32'h0);
    tbl[5]  = mk(0, 32'h0,  32'h0,        1, 1, 8'h11, 32'h80,  32'h12345678, 1, 0, 0, 8'h00, 32'h0);
    tbl[6]  = mk(0, 32'h0,  32'h0,        1, 0, 8'h12, 32'h80,  32'h0,        1, 0, 0, 8'h00, 32'h0);
    tbl[7]  = mk(0, 32'h0,  32'h0,        0, 0, 8'h00, 32'h0,   32'h0,        1, 1, 1, 8'h11, 32'h0);
    tbl[8]  = mk(0, 32'h0,  32'h0,        0, 0, 8'h00, 32'h0,   32'h0,        1, 1, 0, 8'h12, 32'h12345678);
    tbl[9]  = mk(0, 32'h0,  32'h0,        0, 0, 8'h00, 32'h0,   32'h0,        1, 0, 0, 8'h00, 32'h0);
    tbl[10] = mk(0, 32'h0,  32'h0,        1, 0, 8'h20, 32'h443, 32'h0,        1, 0, 0, 8'h00, 32'h0);
    tbl[11] = mk(0, 32'h0,  32'h0,        0, 0, 8'h00, 32'h0,   32'h0,        1, 0, 0, 8'h00, 32'h0);
    tbl[12] = mk(0, 32'h0,  32'h0,        0, 0, 8'h00, 32'h0,   32'h0,        1, 1, 0, 8'h20, 32'hDEADBEEF);
    tbl[13] = mk(0, 32'h0,  32'h0,        0, 0, 8'h00, 32'h0,   32'h0,        1, 0, 0, 8'h00, 32'h0);

    rst = 1; resp_rdy = 1; drive_idle();
    @(posedge clk); #1;
    mon_en = 1;
    @(posedge clk); #1;
    rst = 0;
    @(negedge clk);
    check("reset_rdy_first_cycle", req_rdy, 1);
    check("reset_resp_val", resp_val, 0);
    check("reset_resp_fields", {resp_op, resp_opaque, resp_data}, 0);

    // preload the whole array so every read has a known value
    for (int i = 0; i < P_WORDS; i++) begin
      @(posedge clk); #1;
      init_en = 1; init_addr = 32'(i) << 2; init_data = pat(i);
    end
    @(posedge clk); #1; drive_idle();

    for (int i = 0; i < 14; i++) begin
      init_en = tbl[i].ie; init_addr = tbl[i].ia; init_data = tbl[i].id;
      req_val = tbl[i].rv; req_op = tbl[i].ro; req_opaque = tbl[i].q;
      req_addr = tbl[i].a; req_data = tbl[i].d;
      @(negedge clk);
      check($sformatf("vec%0d_req_rdy", i), req_rdy, tbl[i].er);
      check($sformatf("vec%0d_resp_val", i), resp_val, tbl[i].ev);
      if (tbl[i].ev) begin
        check($sformatf("vec%0d_resp_op", i), resp_op, tbl[i].eo);
        check($sformatf("vec%0d_resp_opaque", i), resp_opaque, tbl[i].eq);
        check($sformatf("vec%0d_resp_data", i), resp_data, tbl[i].ed);
      end
      @(posedge clk); #1;
    end
    drive_idle();

    // backpressure: exactly P_DEPTH accepted, then in-order drain and credit return
    resp_rdy = 0; acc = 0;
    for (int c = 0; c < 8; c++) begin
      req_val = 1; req_op = 0; req_opaque = 8'(acc); req_addr = 32'(c) << 2;
      @(negedge clk);
      if (req_rdy) acc++;
      @(posedge clk); #1;
    end
    drive_idle();
    check("bp_accepted", acc, P_DEPTH);
    @(negedge clk);
    check("bp_full_rdy", req_rdy, 0);
    @(posedge clk); #1; resp_rdy = 1;
    @(negedge clk);
    check("bp_first_opaque", resp_opaque, 0);
    check("bp_rdy_at_first_deq", req_rdy, 0);
    @(negedge clk);
    check("bp_credit_return", req_rdy, 1);
    for (int k = 1; k < P_DEPTH; k++) begin
      if (k > 1) @(negedge clk);
      check($sformatf("bp_opaque%0d", k), resp_opaque, k);
    end
    @(negedge clk);
    check("bp_drained", resp_val, 0);

    // streaming reads at full rate
    @(posedge clk); #1;
    base = n_deq; drops = 0;
    for (int c = 0; c < 16; c++) begin
      req_val = 1; req_op = 0; req_opaque = 8'(8'h40 + c);
      req_addr = 32'($urandom_range(0, 1023)) & 32'hFFFF_FFFC;
      @(negedge clk);
      if (!req_rdy) drops++;
      @(posedge clk); #1;
    end
    drive_idle();
    repeat (10) @(negedge clk);
    check("stream_rdy_drops", drops, 0);
    check("stream_resp_count", n_deq - base, 16);

    // reset with requests outstanding; memory must survive
    @(posedge clk); #1;
    req_val = 1; req_op = 1; req_addr = 32'h200; req_data = 32'hCAFEF00D; req_opaque = 8'h5F;
    @(posedge clk); #1; drive_idle();
    repeat (5) @(posedge clk); #1;
    resp_rdy = 0;
    for (int c = 0; c < 3; c++) begin
      req_val = 1; req_op = 0; req_addr = 32'(c) << 2; req_opaque = 8'(8'h60 + c);
      @(posedge clk); #1;
    end
    drive_idle(); rst = 1;
    @(negedge clk);
    check("rst_rdy_low", req_rdy, 0);
    @(posedge clk); #1; rst = 0;
    @(negedge clk);
    check("rst_resp_val_cleared", resp_val, 0);
    check("rst_rdy_back", req_rdy, 1);
    check("rst_resp_fields_zero", {resp_op, resp_opaque, resp_data}, 0);
    @(posedge clk); #1;
    resp_rdy = 1; req_val = 1; req_op = 0; req_addr = 32'h200; req_opaque = 8'h70;
    @(posedge clk); #1; drive_idle();
    got = 0;
    for (int c = 0; c < 10 && got == 0; c++) begin
      @(negedge clk);
      if (resp_val) begin
        got = 1;
        check("rst_retained_data", resp_data, 32'hCAFEF00D);
        check("rst_retained_opaque", resp_opaque, 8'h70);
      end
    end
    check("rst_resp_seen", got, 1);

    // init collides with a request: request waits one cycle
    @(posedge clk); #1;
    req_val = 1; req_op = 0; req_addr = 32'h40; req_opaque = 8'h77;
    init_en = 1; init_addr = 32'h300; init_data = 32'h0BADF00D;
    @(negedge clk);
    check("init_blocks_rdy", req_rdy, 0);
    @(posedge clk); #1; init_en = 0;
    @(negedge clk);
    check("init_then_accept", req_rdy, 1);
    @(posedge clk); #1; drive_idle();
    got = 0;
    for (int c = 0; c < 10 && got == 0; c++) begin
      @(negedge clk);
      if (resp_val) begin
        got = 1;
        check("init_req_opaque", resp_opaque, 8'h77);
        check("init_req_data", resp_data, 32'hDEADBEEF);
      end
    end
    check("init_resp_seen", got, 1);

    // randomized traffic against the reference model
    for (int c = 0; c < 3000; c++) begin
      @(posedge clk); #1;
      rst        = ($urandom_range(0, 299) == 0);
      init_en    = ($urandom_range(0, 15) == 0);
      init_addr  = (32'($urandom_range(0, 15)) << 2) | 32'($urandom_range(0, 3));
      init_data  = $urandom;
      req_val    = ($urandom_range(0, 3) != 0);
      req_op     = 1'($urandom_range(0, 1));
      req_opaque = 8'($urandom);
      req_addr   = (32'($urandom_range(0, 15)) << 2) | 32'($urandom_range(0, 3))
                 | (32'($urandom_range(0, 1)) << 10);
      req_data   = $urandom;
      resp_rdy   = ($urandom_range(0, 3) != 0);
    end
    @(posedge clk); #1;
    drive_idle(); rst = 0; resp_rdy = 1;
    for (int c = 0; c < 20 && mq.size() != 0; c++) @(negedge clk);
    check("drain_empty", mq.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
